// File: rtl/tmr_multi.sv
// Multi-channel programmable interval timer: shared prescaler, NCHAN one-shot/periodic down-counters.
// Optional channel chaining is compiled in with `define TMR_CASCADE_EN.
module tmr_multi #(
    parameter int NCHAN    = 4,
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 50000,
    parameter int CH_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stb,
    input  logic             we,
    input  logic [CH_W+1:0]  addr,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    output logic             ack,
    output logic             irq
);

    localparam int PRE_W = $clog2(PRESCALE);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    logic [NCHAN-1:0] en;
    logic [NCHAN-1:0] ien;
    logic [NCHAN-1:0] periodic;
    logic [NCHAN-1:0] expired;
    logic [CNT_W-1:0] load  [NCHAN];
    logic [CNT_W-1:0] count [NCHAN];
`ifdef TMR_CASCADE_EN
    logic [NCHAN-1:0] cascade;
`endif

    logic [1:0]       reg_sel;
    logic [CH_W-1:0]  ch_sel;
    logic             ch_valid;
    logic [NCHAN-1:0] wr_ctrl;
    logic [NCHAN-1:0] wr_load;
    logic [NCHAN-1:0] wr_count;
    logic [NCHAN-1:0] wr_status;
    logic [NCHAN-1:0] dec_evt;
    logic [NCHAN-1:0] expire;

    assign reg_sel  = addr[1:0];
    assign ch_sel   = addr[CH_W+1:2];
    assign ch_valid = (int'(ch_sel) < NCHAN);
    assign ack      = stb;
    assign irq      = |(expired & ien);

    // Tick is registered so it lands one cycle after the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (pre_cnt == PRE_W'(PRESCALE - 1)) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
            tick    <= 1'b0;
        end
    end

    always_comb begin
        logic hit;
`ifdef TMR_CASCADE_EN
        logic prev_exp;
        prev_exp = 1'b0;
`endif
        hit       = 1'b0;
        wr_ctrl   = '0;
        wr_load   = '0;
        wr_count  = '0;
        wr_status = '0;
        dec_evt   = '0;
        expire    = '0;
        for (int i = 0; i < NCHAN; i++) begin
            hit          = stb && we && ch_valid && (int'(ch_sel) == i);
            wr_ctrl[i]   = hit && (reg_sel == 2'd0);
            wr_load[i]   = hit && (reg_sel == 2'd1);
            wr_count[i]  = hit && (reg_sel == 2'd2);
            wr_status[i] = hit && (reg_sel == 2'd3);
            dec_evt[i]   = tick;
`ifdef TMR_CASCADE_EN
            // A chained channel counts the expiry pulses of the channel below it.
            if (i > 0 && cascade[i]) begin
                dec_evt[i] = prev_exp;
            end
`endif
            expire[i] = dec_evt[i] && en[i] && (count[i] <= CNT_W'(1));
`ifdef TMR_CASCADE_EN
            prev_exp = expire[i];
`endif
        end
    end

    // Bus writes are applied after the counting update so they take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= '0;
            ien      <= '0;
            periodic <= '0;
            expired  <= '0;
`ifdef TMR_CASCADE_EN
            cascade  <= '0;
`endif
            for (int i = 0; i < NCHAN; i++) begin
                load[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (expire[i]) begin
                    if (periodic[i]) begin
                        count[i] <= load[i];
                    end else begin
                        count[i] <= '0;
                        en[i]    <= 1'b0;
                    end
                end else if (dec_evt[i] && en[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end

                if (wr_ctrl[i]) begin
                    en[i]       <= data_in[0];
                    ien[i]      <= data_in[1];
                    periodic[i] <= data_in[2];
`ifdef TMR_CASCADE_EN
                    if (i > 0) begin
                        cascade[i] <= data_in[3];
                    end
`endif
                    if (data_in[0] && !en[i]) begin
                        count[i] <= load[i];
                    end
                end

                if (wr_load[i]) begin
                    load[i] <= data_in[CNT_W-1:0];
                end

                if (wr_count[i]) begin
                    count[i] <= data_in[CNT_W-1:0];
                end

                if (expire[i]) begin
                    expired[i] <= 1'b1;
                end else if (wr_status[i] && data_in[0]) begin
                    expired[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (ch_valid) begin
            case (reg_sel)
                2'd0: begin
                    data_out[0] = en[ch_sel];
                    data_out[1] = ien[ch_sel];
                    data_out[2] = periodic[ch_sel];
`ifdef TMR_CASCADE_EN
                    data_out[3] = cascade[ch_sel];
`endif
                end
                2'd1:    data_out[CNT_W-1:0] = load[ch_sel];
                2'd2:    data_out[CNT_W-1:0] = count[ch_sel];
                default: data_out[0] = expired[ch_sel];
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_multi.sv
// Self-checking bench for tmr_multi: directed scenarios then random bus traffic,
// all compared against a cycle-level behavioural model of the timer registers.
module tb_tmr_multi;

    localparam int NCHAN    = 5;
    localparam int CNT_W    = 16;
    localparam int PRESCALE = 4;
    localparam int CH_W     = 3;
    localparam int AW       = CH_W + 2;
    localparam int unsigned CMASK = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          ack;
    logic          irq;

    tmr_multi #(
        .NCHAN(NCHAN), .CNT_W(CNT_W), .PRESCALE(PRESCALE), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model state, one entry per addressable channel slot.
    int          edges;
    bit          m_en [8];
    bit          m_ien [8];
    bit          m_per [8];
    bit          m_casc [8];
    bit          m_exp [8];
    int unsigned m_load [8];
    int unsigned m_cnt [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit is_tick_edge(input int e);
        return (e > 1) && ((e - 1) % PRESCALE == 0);
    endfunction

    task automatic model_reset();
        edges = 0;
        for (int i = 0; i < 8; i++) begin
            m_en[i] = 0; m_ien[i] = 0; m_per[i] = 0; m_casc[i] = 0; m_exp[i] = 0;
            m_load[i] = 0; m_cnt[i] = 0;
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        int ch = a / 4;
        int r  = a % 4;
        if (ch >= NCHAN) return 32'd0;
        case (r)
            0: return {28'd0, m_casc[ch], m_per[ch], m_ien[ch], m_en[ch]};
            1: return m_load[ch];
            2: return m_cnt[ch];
            default: return {31'd0, m_exp[ch]};
        endcase
    endfunction

    function automatic bit m_irq();
        bit v = 0;
        for (int i = 0; i < NCHAN; i++) v |= m_exp[i] & m_ien[i];
        return v;
    endfunction

    task automatic model_edge(input bit s, input bit w, input int a, input logic [31:0] d);
        bit tk;
        bit ev [8];
        bit ex [8];
        int ch;
        int r;
        bit old_en;
        edges++;
        tk = is_tick_edge(edges);
        for (int i = 0; i < 8; i++) begin
            ev[i] = 0;
            ex[i] = 0;
        end
        for (int i = 0; i < NCHAN; i++) begin
            ev[i] = tk;
`ifdef TMR_CASCADE_EN
            if (i > 0 && m_casc[i]) ev[i] = ex[i-1];
`endif
            ex[i] = ev[i] && m_en[i] && (m_cnt[i] <= 1);
        end
        ch = a / 4;
        r  = a % 4;
        old_en = m_en[ch];
        for (int i = 0; i < NCHAN; i++) begin
            if (ex[i]) begin
                m_exp[i] = 1;
                if (m_per[i]) m_cnt[i] = m_load[i];
                else begin
                    m_cnt[i] = 0;
                    m_en[i]  = 0;
                end
            end else if (ev[i] && m_en[i]) begin
                m_cnt[i] = m_cnt[i] - 1;
            end
        end
        if (s && w && ch < NCHAN) begin
            case (r)
                0: begin
                    if (d[0] && !old_en) m_cnt[ch] = m_load[ch];
                    m_en[ch]  = d[0];
                    m_ien[ch] = d[1];
                    m_per[ch] = d[2];
`ifdef TMR_CASCADE_EN
                    if (ch > 0) m_casc[ch] = d[3];
`endif
                end
                1: m_load[ch] = int'(d) & CMASK;
                2: m_cnt[ch]  = int'(d) & CMASK;
                default: if (d[0] && !ex[ch]) m_exp[ch] = 0;
            endcase
        end
    endtask

    // One bus cycle: drive at negedge, check just before the edge, advance model at the edge.
    task automatic step(input bit s, input bit w, input int a, input logic [31:0] d,
                        input string tag, output logic [31:0] rdv);
        @(negedge clk);
        stb = s; we = w; addr = AW'(a); data_in = d;
        #1;
        rdv = data_out;
        chk({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq()});
        chk({tag, "_ack"}, {31'd0, ack}, {31'd0, s});
        if (s && !w) chk(tag, data_out, m_read(a));
        @(posedge clk);
        model_edge(s, w, a, d);
        #1;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        logic [31:0] x;
        step(1, 1, ch * 4 + r, d, "wr", x);
    endtask

    task automatic rd(input int ch, input int r, input string tag, output logic [31:0] v);
        step(1, 0, ch * 4 + r, 32'd0, tag, v);
    endtask

    task automatic wait_ticks(input int n);
        logic [31:0] x;
        for (int k = 0; k < n; k++) begin
            do step(0, 0, 0, 32'd0, "idle", x); while (!is_tick_edge(edges));
        end
    endtask

    task automatic to_tick_edge();
        logic [31:0] x;
        while (!is_tick_edge(edges + 1)) step(0, 0, 0, 32'd0, "idle", x);
    endtask

    initial begin
        logic [31:0] v;
        int first_k;
        int exp_k;

        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        stb = 1'b1; addr = AW'(2); #1;
        chk("rst_init_count", data_out, 32'd0);
        chk("rst_init_irq", {31'd0, irq}, 32'd0);
        stb = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;

        // Reset in the middle of activity
        wr(0, 1, 1); wr(0, 0, 3); wr(2, 1, 100); wr(2, 0, 5);
        wait_ticks(1);
        chk("rst_pre_irq", {31'd0, irq}, 32'd1);
        @(negedge clk); #1 rst_n = 1'b0; #1;
        chk("rst_async_irq", {31'd0, irq}, 32'd0);
        stb = 1'b1;
        addr = AW'(3);  #1 chk("rst_ch0_status", data_out, 32'd0);
        addr = AW'(1);  #1 chk("rst_ch0_load", data_out, 32'd0);
        addr = AW'(8);  #1 chk("rst_ch2_ctrl", data_out, 32'd0);
        addr = AW'(10); #1 chk("rst_ch2_count", data_out, 32'd0);
        stb = 1'b0;
        model_reset();
        @(posedge clk); #2 rst_n = 1'b1;
        wait_ticks(3);
        rd(2, 3, "rst_no_expiry", v); chk("rst_ch2_status_after", v, 32'd0);

        // One-shot
        wait_ticks(1);
        wr(0, 1, 3); wr(0, 0, 3);
        rd(0, 2, "os_count0", v); chk("os_count_armed", v, 32'd3);
        wait_ticks(2);
        rd(0, 3, "os_status2", v); chk("os_not_yet", v, 32'd0);
        wait_ticks(1);
        rd(0, 3, "os_status3", v); chk("os_expired", v, 32'd1);
        chk("os_irq", {31'd0, irq}, 32'd1);
        rd(0, 2, "os_count_end", v); chk("os_count_zero", v, 32'd0);
        rd(0, 0, "os_ctrl_end", v); chk("os_en_cleared", v, 32'd2);
        wr(0, 3, 1);
        wait_ticks(3);
        rd(0, 3, "os_status_after", v); chk("os_no_reexpiry", v, 32'd0);

        // Periodic
        wait_ticks(1);
        wr(2, 1, 2); wr(2, 0, 7);
        rd(2, 2, "per_c0", v); chk("per_seq0", v, 32'd2);
        wait_ticks(1);
        rd(2, 2, "per_c1", v); chk("per_seq1", v, 32'd1);
        wait_ticks(1);
        rd(2, 2, "per_c2", v); chk("per_seq2", v, 32'd2);
        rd(2, 3, "per_st", v); chk("per_expired", v, 32'd1);
        wait_ticks(1);
        rd(2, 2, "per_c3", v); chk("per_seq3", v, 32'd1);
        wr(2, 3, 1);
        to_tick_edge();
        wr(2, 3, 1);
        rd(2, 3, "per_set_wins", v); chk("per_set_beats_clear", v, 32'd1);
        wr(2, 0, 0); wr(2, 3, 1);

        // IRQ masking
        wait_ticks(1);
        wr(3, 1, 1); wr(3, 0, 1);
        wait_ticks(1);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        rd(3, 3, "mask_status", v); chk("mask_status_set", v, 32'd1);
        wr(3, 0, 2);
        chk("irq_unmasked", {31'd0, irq}, 32'd1);
        wr(3, 3, 1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // Bus write racing a tick, and unused channel addresses
        wait_ticks(1);
        wr(4, 1, 10); wr(4, 0, 5);
        to_tick_edge();
        wr(4, 2, 5);
        rd(4, 2, "race_cnt", v); chk("race_count_write_wins", v, 32'd5);
        wr(4, 2, 1);
        to_tick_edge();
        wr(4, 2, 7);
        rd(4, 2, "race_cnt7", v); chk("race_count7", v, 32'd7);
        rd(4, 3, "race_st", v); chk("race_expiry_kept", v, 32'd1);
        for (int r = 0; r < 4; r++) begin
            rd(5, r, "unused5", v); chk("unused_ch5_zero", v, 32'd0);
        end
        wr(5, 0, 32'hF); wr(5, 1, 9); wr(5, 2, 9); wr(7, 1, 9);
        for (int c = 0; c < NCHAN; c++)
            for (int r = 0; r < 4; r++) rd(c, r, "unused_no_effect", v);

        // Cascade
        wr(4, 0, 0); wr(4, 3, 1);
        wait_ticks(1);
        wr(0, 1, 2); wr(1, 1, 3); wr(1, 3, 1);
        wait_ticks(1);
        wr(0, 0, 5); wr(1, 0, 9);
        rd(1, 0, "casc_ctrl", v);
`ifdef TMR_CASCADE_EN
        chk("casc_ctrl_bit", v, 32'd9);
        exp_k = 6;
`else
        chk("casc_ctrl_bit", v, 32'd1);
        exp_k = 3;
`endif
        first_k = 0;
        for (int k = 1; k <= 8; k++) begin
            wait_ticks(1);
            rd(1, 3, "casc_st", v);
            if (v[0] && first_k == 0) first_k = k;
        end
        chk("casc_expiry_tick", first_k, exp_k);
        wr(0, 0, 0);

        // Random bus traffic against the model
        for (int n = 0; n < 400; n++) begin
            int ch = $urandom_range(0, 7);
            int r  = $urandom_range(0, 3);
            bit s  = ($urandom_range(0, 3) != 0);
            bit w  = $urandom_range(0, 1);
            logic [31:0] d;
            case (r)
                0: d = $urandom_range(0, 15);
                1, 2: d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 6);
                default: d = $urandom_range(0, 1);
            endcase
            step(s, w, ch * 4 + r, d, "rand", v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
